// File: rtl/vga_stream_out.sv
// VGA output engine: programmable raster timing, valid/ready RGB stream aligned to start-of-frame,
// underflow/misalignment detection with automatic resync, and a built-in colour-bar pattern.
module vga_stream_out #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   test_pat,
  input  logic [3*COLOR_W-1:0]   pix_data,
  input  logic                   pix_sof,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_blank_n,
  output logic                   vga_sync_n,
  output logic                   frame_start,
  output logic                   underflow,
  input  logic                   underflow_clr
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int PIX_W = 3 * COLOR_W;
  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESYNC  = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  state_t            state;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;

  logic              running;
  logic              active;
  logic              first_px;
  logic              last_px;
  logic              hs_on;
  logic              vs_on;
  logic              sof_ok;
  logic              err;
  logic              accept;
  logic              sof_lock;
  logic [2:0]        bar_idx;

  logic [PIX_W-1:0]  rgb_p1;
  logic              hs_p1;
  logic              vs_p1;
  logic              blank_n_p1;
  logic              fs_p1;
  logic              uf_p1;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out of the index bits.
  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
    return {{COLOR_W{~idx[1]}}, {COLOR_W{~idx[2]}}, {COLOR_W{~idx[0]}}};
  endfunction

  always_comb begin
    running  = enable && (state != IDLE);
    active   = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    first_px = (h_cnt == '0) && (v_cnt == '0);
    last_px  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    hs_on    = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    vs_on    = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    sof_ok   = (pix_sof == first_px);
  end

  // Bar index by threshold count avoids a divider on the pixel path.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h_cnt) >= k * BAR_W) bar_idx = bar_idx + 3'd1;
    end
  end

  // While resyncing, non-SOF beats are drained and the SOF beat is parked until the raster wraps.
  always_comb begin
    pix_ready = 1'b0;
    if (running && !test_pat) begin
      case (state)
        RESYNC:  pix_ready = pix_valid & ~pix_sof;
        ALIGNED: pix_ready = active & ~(pix_valid & ~sof_ok);
        default: pix_ready = 1'b0;
      endcase
    end
    err      = running && !test_pat && (state == ALIGNED) && active && !(pix_valid && sof_ok);
    accept   = running && !test_pat && (state == ALIGNED) && active && pix_valid && sof_ok;
    sof_lock = running && !test_pat && (state == RESYNC) && pix_valid && pix_sof && last_px;
  end

  // Stage p0 -> p1: raster counters and state drive the registered pin image.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      rgb_p1     <= '0;
      hs_p1      <= ~HS_POL;
      vs_p1      <= ~VS_POL;
      blank_n_p1 <= 1'b0;
      fs_p1      <= 1'b0;
      uf_p1      <= 1'b0;
    end else begin
      if (err)                uf_p1 <= 1'b1;
      else if (underflow_clr) uf_p1 <= 1'b0;

      if (!running) begin
        state      <= enable ? RESYNC : IDLE;
        h_cnt      <= '0;
        v_cnt      <= '0;
        rgb_p1     <= '0;
        hs_p1      <= ~HS_POL;
        vs_p1      <= ~VS_POL;
        blank_n_p1 <= 1'b0;
        fs_p1      <= 1'b0;
      end else begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end

        hs_p1      <= hs_on ? HS_POL : ~HS_POL;
        vs_p1      <= vs_on ? VS_POL : ~VS_POL;
        blank_n_p1 <= active;
        fs_p1      <= first_px;

        if (test_pat && active) rgb_p1 <= bar_color(bar_idx);
        else if (accept)        rgb_p1 <= pix_data;
        else                    rgb_p1 <= '0;

        if (test_pat)      state <= RESYNC;
        else if (sof_lock) state <= ALIGNED;
        else if (err)      state <= RESYNC;
      end
    end
  end

  assign vga_r       = rgb_p1[3*COLOR_W-1:2*COLOR_W];
  assign vga_g       = rgb_p1[2*COLOR_W-1:COLOR_W];
  assign vga_b       = rgb_p1[COLOR_W-1:0];
  assign vga_hs      = hs_p1;
  assign vga_vs      = vs_p1;
  assign vga_blank_n = blank_n_p1;
  assign vga_sync_n  = 1'b1;
  assign frame_start = fs_p1;
  assign underflow   = uf_p1;

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out: random pixel streams against a raster-position reference model.
module tb_vga_stream_out;
  localparam int HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int CW = 8;
  localparam int H_TOT = HA + HF + HS + HB;
  localparam int V_TOT = VA + VF + VS + VB;
  localparam int F_TOT = H_TOT * V_TOT;
  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b0;
  localparam logic [29:0] IDLE_PINS = {24'h0, ~HS_POL, ~VS_POL, 1'b0, 1'b1, 1'b0, 1'b0};

  typedef struct packed {
    logic        sof;
    logic [23:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n, enable, test_pat, pix_sof, pix_valid, pix_ready, underflow_clr;
  logic [23:0] pix_data;
  logic [CW-1:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, underflow;

  always #5 clk = ~clk;

  vga_stream_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .COLOR_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .test_pat(test_pat),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .frame_start(frame_start),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  int checks = 0;
  int fails  = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  beat_t src_q[$];
  logic  drop = 1'b0;

  // Reference model: raster position is derived from elapsed running cycles.
  logic        m_on = 1'b0;
  logic        m_al = 1'b0;
  logic        m_uf = 1'b0;
  int          m_t  = 0;
  logic        exp_ready, act_ready;
  logic [29:0] exp_pins, act_pins;

  task automatic push_frame();
    for (int i = 0; i < HA * VA; i++) src_q.push_back({(i == 0), 24'($urandom)});
  endtask

  // One pixel clock: present the source head, predict, clock, capture pins.
  task automatic cyc();
    beat_t       hd;
    int          h, v;
    logic        act, first, last, err;
    logic [23:0] e_rgb;
    logic        e_hs, e_vs, e_bl, e_fs;
    hd        = (src_q.size() > 0) ? src_q[0] : '0;
    pix_valid = (src_q.size() > 0) && !drop;
    pix_sof   = pix_valid ? hd.sof : 1'b0;
    pix_data  = pix_valid ? hd.data : 24'($urandom);
    #1;
    h     = m_t % H_TOT;
    v     = (m_t / H_TOT) % V_TOT;
    act   = (h < HA) && (v < VA);
    first = (h == 0) && (v == 0);
    last  = (h == H_TOT - 1) && (v == V_TOT - 1);
    err   = 1'b0;
    e_rgb = 24'h0; e_hs = ~HS_POL; e_vs = ~VS_POL; e_bl = 1'b0; e_fs = 1'b0;
    exp_ready = 1'b0;
    if (!m_on || !enable) begin
      m_on = !m_on && enable;
      m_t  = 0;
      m_al = 1'b0;
    end else begin
      e_hs = (h >= HA + HF && h < HA + HF + HS) ? HS_POL : ~HS_POL;
      e_vs = (v >= VA + VF && v < VA + VF + VS) ? VS_POL : ~VS_POL;
      e_bl = act;
      e_fs = first;
      if (test_pat) begin
        if (act) e_rgb = bars[h / (HA / 8)];
        m_al = 1'b0;
      end else if (!m_al) begin
        exp_ready = pix_valid && !pix_sof;
        if (pix_valid && pix_sof && last) m_al = 1'b1;
      end else if (act) begin
        if (pix_valid && (pix_sof == first)) begin
          exp_ready = 1'b1;
          e_rgb     = pix_data;
        end else begin
          exp_ready = !pix_valid;
          err       = 1'b1;
          m_al      = 1'b0;
        end
      end
      m_t++;
    end
    m_uf = err ? 1'b1 : (underflow_clr ? 1'b0 : m_uf);
    exp_pins  = {e_rgb, e_hs, e_vs, e_bl, 1'b1, e_fs, m_uf};
    act_ready = pix_ready;
    @(posedge clk);
    if (pix_valid && pix_ready) src_q.delete(0);
    #1;
    act_pins = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, underflow};
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; test_pat = 1'b0; underflow_clr = 1'b0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pix_ready, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, underflow}
        !== {1'b0, IDLE_PINS}) begin
      fails++;
      $display("FAIL reset_state got %h want %h", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
               vga_sync_n, frame_start, underflow}, IDLE_PINS);
    end
    reset_n = 1'b1;
    cyc();
    checks++;
    if ({act_ready, act_pins} !== {exp_ready, exp_pins}) begin
      fails++;
      $display("FAIL idle_after_reset got %b/%h want %b/%h", act_ready, act_pins, exp_ready, exp_pins);
    end
  endtask

  task automatic test_pattern();
    int hs_n = 0, bl_n = 0, fs_n = 0;
    enable = 1'b1; test_pat = 1'b1;
    for (int i = 0; i < 1 + 2 * F_TOT; i++) begin
      cyc();
      checks++;
      if ({act_ready, act_pins} !== {exp_ready, exp_pins}) begin
        fails++;
        $display("FAIL pattern t=%0d got %b/%h want %b/%h", m_t, act_ready, act_pins, exp_ready, exp_pins);
      end
      if (vga_hs == HS_POL) hs_n++;
      if (vga_blank_n) bl_n++;
      if (frame_start) fs_n++;
    end
    checks++;
    if (hs_n != 2 * V_TOT * HS || bl_n != 2 * HA * VA || fs_n != 2) begin
      fails++;
      $display("FAIL pattern_counts hs=%0d blank=%0d fs=%0d want %0d %0d 2", hs_n, bl_n, fs_n,
               2 * V_TOT * HS, 2 * HA * VA);
    end
    enable = 1'b0; test_pat = 1'b0;
    cyc();
  endtask

  task automatic test_stream();
    int fs_n = 0;
    repeat (3) push_frame();
    enable = 1'b1;
    for (int i = 0; i < 1 + 4 * F_TOT; i++) begin
      cyc();
      checks++;
      if ({act_ready, act_pins} !== {exp_ready, exp_pins}) begin
        fails++;
        $display("FAIL stream t=%0d got %b/%h want %b/%h", m_t, act_ready, act_pins, exp_ready, exp_pins);
      end
      if (frame_start) fs_n++;
    end
    checks++;
    if (src_q.size() != 0 || underflow !== 1'b0 || fs_n != 4) begin
      fails++;
      $display("FAIL stream_end left=%0d uf=%b fs=%0d want 0 0 4", src_q.size(), underflow, fs_n);
    end
    enable = 1'b0;
    cyc();
  endtask

  task automatic test_underflow();
    logic done = 1'b0;
    repeat (3) push_frame();
    enable = 1'b1;
    for (int i = 0; i < 1 + 4 * F_TOT; i++) begin
      drop = m_on && m_al && !done && (m_t % H_TOT == 3) && ((m_t / H_TOT) % V_TOT == 1);
      cyc();
      checks++;
      if ({act_ready, act_pins} !== {exp_ready, exp_pins}) begin
        fails++;
        $display("FAIL underflow t=%0d got %b/%h want %b/%h", m_t, act_ready, act_pins, exp_ready, exp_pins);
      end
      if (drop) begin
        done = 1'b1;
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h0 || underflow !== 1'b1) begin
          fails++;
          $display("FAIL drop_pixel rgb=%h uf=%b want 000000 1", {vga_r, vga_g, vga_b}, underflow);
        end
      end
      drop = 1'b0;
    end
    checks++;
    if (!done || src_q.size() != 0 || underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_end dropped=%b left=%0d uf=%b want 1 0 1", done, src_q.size(), underflow);
    end
    enable = 1'b0;
    cyc();
  endtask

  task automatic test_clear();
    underflow_clr = 1'b1;
    cyc();
    underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0 || act_pins !== exp_pins) begin
      fails++;
      $display("FAIL clear uf=%b pins=%h want 0 %h", underflow, act_pins, exp_pins);
    end
  endtask

  task automatic test_presof();
    int fs_n = 0;
    logic [23:0] sof_data;
    repeat (5) src_q.push_back({1'b0, 24'($urandom)});
    push_frame();
    sof_data = src_q[5].data;
    push_frame();
    enable = 1'b1;
    for (int i = 0; i < 1 + 3 * F_TOT; i++) begin
      cyc();
      checks++;
      if ({act_ready, act_pins} !== {exp_ready, exp_pins}) begin
        fails++;
        $display("FAIL presof t=%0d got %b/%h want %b/%h", m_t, act_ready, act_pins, exp_ready, exp_pins);
      end
      if (frame_start) begin
        fs_n++;
        if (fs_n == 2) begin
          checks++;
          if ({vga_r, vga_g, vga_b} !== sof_data) begin
            fails++;
            $display("FAIL presof_first rgb=%h want %h", {vga_r, vga_g, vga_b}, sof_data);
          end
        end
      end
    end
    checks++;
    if (src_q.size() != 0 || underflow !== 1'b0) begin
      fails++;
      $display("FAIL presof_end left=%0d uf=%b want 0 0", src_q.size(), underflow);
    end
    enable = 1'b0;
    cyc();
  endtask

  task automatic test_disable();
    repeat (2) push_frame();
    enable = 1'b1;
    for (int i = 0; i < 1 + 2 * F_TOT; i++) begin
      if (m_on && m_t == F_TOT + 2 * H_TOT + 5) enable = 1'b0;
      cyc();
      checks++;
      if ({act_ready, act_pins} !== {exp_ready, exp_pins}) begin
        fails++;
        $display("FAIL disable t=%0d got %b/%h want %b/%h", m_t, act_ready, act_pins, exp_ready, exp_pins);
      end
      if (!enable) break;
    end
    cyc();
    checks++;
    if (enable || act_ready !== 1'b0 || vga_blank_n !== 1'b0 || vga_hs !== ~HS_POL ||
        vga_vs !== ~VS_POL || underflow !== 1'b0) begin
      fails++;
      $display("FAIL disable_idle en=%b rdy=%b blank=%b hs=%b vs=%b uf=%b want 0 0 0 %b %b 0",
               enable, act_ready, vga_blank_n, vga_hs, vga_vs, underflow, ~HS_POL, ~VS_POL);
    end
    src_q.delete();
    enable = 1'b1; test_pat = 1'b1;
    cyc();
    cyc();
    checks++;
    if (frame_start !== 1'b1 || vga_blank_n !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'hFFFFFF) begin
      fails++;
      $display("FAIL reenable fs=%b blank=%b rgb=%h want 1 1 ffffff", frame_start, vga_blank_n,
               {vga_r, vga_g, vga_b});
    end
    enable = 1'b0; test_pat = 1'b0;
    cyc();
  endtask

  task automatic test_clr_collision();
    logic hit = 1'b0;
    push_frame();
    enable = 1'b1;
    for (int i = 0; i < 1 + 3 * F_TOT; i++) begin
      underflow_clr = m_on && m_al && (m_t % F_TOT == 0) && (src_q.size() == 0);
      cyc();
      checks++;
      if ({act_ready, act_pins} !== {exp_ready, exp_pins}) begin
        fails++;
        $display("FAIL collision t=%0d got %b/%h want %b/%h", m_t, act_ready, act_pins, exp_ready, exp_pins);
      end
      if (underflow_clr) begin
        hit = 1'b1;
        underflow_clr = 1'b0;
        break;
      end
    end
    checks++;
    if (!hit || underflow !== 1'b1) begin
      fails++;
      $display("FAIL collision_set_wins reached=%b uf=%b want 1 1", hit, underflow);
    end
    cyc();
    checks++;
    if (underflow !== 1'b1) begin
      fails++;
      $display("FAIL collision_sticky uf=%b want 1", underflow);
    end
    underflow_clr = 1'b1;
    cyc();
    underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      fails++;
      $display("FAIL collision_clear uf=%b want 0", underflow);
    end
    enable = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pattern();
    test_stream();
    test_underflow();
    test_clear();
    test_presof();
    test_disable();
    test_clr_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
